// File: rtl/dsched_pkg.sv
// dsched_pkg: shared types and constants for delay_sched_ctrl (slot_t is sized for the default configuration)
package dsched_pkg;
  localparam int NREQ_D = 4;
  localparam int DW_D = 1;
  localparam int DLY_W_D = 4;
  localparam int SLOTS_D = 8;
  localparam int SRC_W = $clog2(NREQ_D);
  localparam int LATE_W = 16;
  typedef enum logic {
    MODE_INTRA = 1'b0,
    MODE_INTER = 1'b1
  } mode_e;
  typedef struct packed {
    logic valid;
    logic [DLY_W_D-1:0] cnt;
    logic [SRC_W-1:0] src;
    mode_e mode;
    logic [DW_D-1:0] data;
  } slot_t;
endpackage

// File: rtl/dsched_rr_arb.sv
// dsched_rr_arb: NREQ-way round-robin arbiter, combinational grant, pointer advanced on transfer
module dsched_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [$clog2(NREQ)-1:0] gidx
);
  logic [$clog2(NREQ)-1:0] ptr;
  logic found;
  int idx;
  // Grant the first requester found after the last granted one
  always_comb begin
    grant = '0;
    gidx = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        gidx = idx[$clog2(NREQ)-1:0];
      end
    end
  end
  // Pointer moves only when a grant becomes a transfer; reset makes requester 0 first
  always_ff @(posedge clk) begin
    if (rst) ptr <= $clog2(NREQ)'(NREQ - 1);
    else if (found) ptr <= gidx;
  end
endmodule

// File: rtl/delay_sched_ctrl.sv
// delay_sched_ctrl: delayed-update event scheduler; DSCHED_LATE_CNT_EN enables the stall counter
module delay_sched_ctrl
  import dsched_pkg::*;
#(
  parameter int NREQ = NREQ_D,
  parameter int DW = DW_D,
  parameter int DLY_W = DLY_W_D,
  parameter int SLOTS = SLOTS_D
) (
  input  logic clk,
  input  logic rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*DLY_W-1:0] req_delay,
  input  logic [NREQ-1:0] req_mode,
  input  logic [NREQ*DW-1:0] live_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [DW-1:0] out_data,
  output logic [$clog2(NREQ)-1:0] out_src,
  output logic [$clog2(SLOTS+1)-1:0] pending,
  output logic [LATE_W-1:0] late_cnt
);
  localparam int IW = $clog2(SLOTS);
  localparam int PCW = $clog2(SLOTS + 1);
  slot_t slots [SLOTS];
  logic free_any, exp_any, load, issue, accept;
  logic [IW-1:0] free_idx, exp_idx;
  logic [$clog2(NREQ)-1:0] gidx;
  logic [DW-1:0] issue_data;
  dsched_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .en(free_any && !rst),
    .req(req_valid),
    .grant(req_ready),
    .gidx(gidx)
  );
  assign accept = |(req_valid & req_ready);
  assign load = !out_valid || out_ready;
  assign issue = load && exp_any;
  assign issue_data = slots[exp_idx].mode == MODE_INTER ? live_data[int'(slots[exp_idx].src)*DW +: DW] : slots[exp_idx].data;
  // Lowest free slot, lowest expired slot and occupancy; scanning downward lets low indices win
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    exp_any = 1'b0;
    exp_idx = '0;
    pending = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (!slots[s].valid) begin
        free_any = 1'b1;
        free_idx = IW'(s);
      end
      if (slots[s].valid && slots[s].cnt == '0) begin
        exp_any = 1'b1;
        exp_idx = IW'(s);
      end
      pending = pending + PCW'(slots[s].valid);
    end
  end
  // Slot table: free on issue, fill on accept, otherwise count down to zero and hold
  always_ff @(posedge clk) begin
    for (int s = 0; s < SLOTS; s++) begin
      if (rst) slots[s] <= '0;
      else if (issue && IW'(s) == exp_idx) slots[s].valid <= 1'b0;
      else if (accept && IW'(s) == free_idx) slots[s] <= '{valid: 1'b1, cnt: req_delay[int'(gidx)*DLY_W +: DLY_W], src: gidx, mode: mode_e'(req_mode[gidx]), data: req_data[int'(gidx)*DW +: DW]};
      else if (slots[s].valid && slots[s].cnt != '0) slots[s].cnt <= slots[s].cnt - 1'b1;
    end
  end
  // Output register reloads when empty or drained; holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
    end else if (load) begin
      out_valid <= exp_any;
      if (exp_any) begin
        out_data <= issue_data;
        out_src <= slots[exp_idx].src;
      end
    end
  end
`ifdef DSCHED_LATE_CNT_EN
  // Saturating count of cycles where an expired event is blocked by a full output
  always_ff @(posedge clk) begin
    if (rst) late_cnt <= '0;
    else if (exp_any && !load && late_cnt != '1) late_cnt <= late_cnt + 1'b1;
  end
`else
  assign late_cnt = '0;
`endif
endmodule

// File: tb/tb_delay_sched_ctrl.sv
// tb_delay_sched_ctrl: directed self-checking bench for delay_sched_ctrl
module tb_delay_sched_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid, req_ready, req_mode, req_data, live_data;
  logic [15:0] req_delay;
  logic out_valid, out_ready;
  logic [0:0] out_data;
  logic [1:0] out_src;
  logic [3:0] pending;
  logic [15:0] late_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  delay_sched_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_delay(req_delay), .req_mode(req_mode),
    .live_data(live_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .pending(pending), .late_cnt(late_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'hF; req_mode = 4'h0; req_data = 4'h0;
    req_delay = 16'h0; live_data = 4'h0; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready0 got %b want 0000", req_ready); end
    tick(); tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready1 got %b want 0000", req_ready); end
    req_valid = 4'h0; rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 1'b0) begin n_bad++; $display("FAIL rst_out_data got %b want 0", out_data); end
    n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL rst_out_src got %0d want 0", out_src); end
    n_cmp++; if (pending !== 4'd0) begin n_bad++; $display("FAIL rst_pending got %0d want 0", pending); end
    n_cmp++; if (late_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_late_cnt got %0d want 0", late_cnt); end
  endtask

  task automatic test_intra_latency;
    req_delay = 16'h0050; req_data = 4'b0010; req_mode = 4'h0; out_ready = 1'b1; req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL lat_grant got %b want 0010", req_ready); end
    tick();
    req_valid = 4'h0;
    #1;
    n_cmp++; if (pending !== 4'd1) begin n_bad++; $display("FAIL lat_pending1 got %0d want 1", pending); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early_%0d got %b want 0", i, out_valid); end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 1'b1) begin n_bad++; $display("FAIL lat_data got %b want 1", out_data); end
    n_cmp++; if (out_src !== 2'd1) begin n_bad++; $display("FAIL lat_src got %0d want 1", out_src); end
    n_cmp++; if (pending !== 4'd0) begin n_bad++; $display("FAIL lat_pending0 got %0d want 0", pending); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_drain got %b want 0", out_valid); end
  endtask

  task automatic test_mode(input logic mode, input logic exp_data);
    live_data = 4'b0001; req_data = 4'b0001; req_delay = 16'h0005;
    req_mode = {3'b000, mode}; req_valid = 4'b0001; out_ready = 1'b1;
    tick();
    req_valid = 4'h0;
    tick(); tick();
    live_data = 4'b0000;
    tick(); tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mode%0b_early got %b want 0", mode, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mode%0b_valid got %b want 1", mode, out_valid); end
    n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL mode%0b_data got %b want %b", mode, out_data, exp_data); end
    n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL mode%0b_src got %0d want 0", mode, out_src); end
    tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    req_valid = 4'hF; req_delay = 16'h0; req_mode = 4'h0; req_data = 4'h0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (req_ready !== (4'b0001 << (k % 4))) begin n_bad++; $display("FAIL b2b_grant_%0d got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      tick();
      if (k >= 1) begin
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'((k - 1) % 4)) begin n_bad++; $display("FAIL b2b_src_%0d got v=%b src=%0d want v=1 src=%0d", k, out_valid, out_src, (k - 1) % 4); end
        n_cmp++; if (pending !== 4'd1) begin n_bad++; $display("FAIL b2b_pending_%0d got %0d want 1", k, pending); end
      end
    end
    req_valid = 4'h0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd3) begin n_bad++; $display("FAIL b2b_last got v=%b src=%0d want v=1 src=3", out_valid, out_src); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || pending !== 4'd0) begin n_bad++; $display("FAIL b2b_idle got v=%b p=%0d want v=0 p=0", out_valid, pending); end
  endtask

  task automatic test_full;
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0001; req_delay = 16'h000F; req_mode = 4'h0; req_data = 4'h0;
    repeat (8) tick();
    n_cmp++; if (pending !== 4'd8) begin n_bad++; $display("FAIL full_pending got %0d want 8", pending); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL full_ready got %b want 0000", req_ready); end
    repeat (8) tick();
    n_cmp++; if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL full_pre_issue got v=%b r=%b want v=0 r=0000", out_valid, req_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin n_bad++; $display("FAIL full_issue got v=%b src=%0d want v=1 src=0", out_valid, out_src); end
    n_cmp++; if (pending !== 4'd7) begin n_bad++; $display("FAIL full_pending7 got %0d want 7", pending); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL full_ready_back got %b want 0001", req_ready); end
    req_valid = 4'h0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || pending !== 4'd7) begin n_bad++; $display("FAIL full_stall got v=%b p=%0d want v=1 p=7", out_valid, pending); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || pending !== 4'd6) begin n_bad++; $display("FAIL full_release got v=%b p=%0d want v=1 p=6", out_valid, pending); end
  endtask

  task automatic test_same_expiry;
    logic [15:0] exp_late;
`ifdef DSCHED_LATE_CNT_EN
    exp_late = 16'd3;
`else
    exp_late = 16'd0;
`endif
    do_reset();
    out_ready = 1'b0; req_mode = 4'h0; req_data = 4'b0001; req_delay = 16'h0034; req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'h0;
    repeat (3) tick();
    n_cmp++; if (out_valid !== 1'b0 || pending !== 4'd2) begin n_bad++; $display("FAIL same_pre got v=%b p=%0d want v=0 p=2", out_valid, pending); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 1'b1) begin n_bad++; $display("FAIL same_hold_%0d got v=%b src=%0d d=%b want v=1 src=0 d=1", i, out_valid, out_src, out_data); end
    end
    n_cmp++; if (late_cnt !== exp_late) begin n_bad++; $display("FAIL same_late got %0d want %0d", late_cnt, exp_late); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 1'b0) begin n_bad++; $display("FAIL same_second got v=%b src=%0d d=%b want v=1 src=1 d=0", out_valid, out_src, out_data); end
    n_cmp++; if (late_cnt !== exp_late) begin n_bad++; $display("FAIL same_late_after got %0d want %0d", late_cnt, exp_late); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || pending !== 4'd0) begin n_bad++; $display("FAIL same_idle got v=%b p=%0d want v=0 p=0", out_valid, pending); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    out_ready = 1'b1; req_mode = 4'h0; req_data = 4'b0111; req_delay = 16'h0555; req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = 4'h0;
    n_cmp++; if (pending !== 4'd3) begin n_bad++; $display("FAIL mid_pending3 got %0d want 3", pending); end
    do_reset();
    n_cmp++; if (out_valid !== 1'b0 || pending !== 4'd0) begin n_bad++; $display("FAIL mid_cleared got v=%b p=%0d want v=0 p=0", out_valid, pending); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale_%0d got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_intra_latency();
    test_mode(1'b1, 1'b0);
    test_mode(1'b0, 1'b1);
    test_back_to_back();
    test_full();
    test_same_expiry();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/delay_sched_ctrl.md
Name: delay_sched_ctrl

Overview:
Scheduler that models procedural-assignment delays in synthesizable RTL. NREQ requesters submit update events, each carrying a value and a delay in clock cycles. A round-robin arbiter admits one event per cycle into a slot table, and each slot counts down its delay. Expired events are issued one per cycle through a valid/ready output register. Per-event mode selects how the value is taken:
- intra mode: value captured at accept, like "x = #d y".
- inter mode: value sampled from the live source at issue, like "#d x = y".

Parameters:
NREQ, 4, number of requesters (>=2)
DW, 1, event data width
DLY_W, 4, delay field width; max delay 2^DLY_W-1 cycles
SLOTS, 8, number of pending-event slots

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester event valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_data  in  NREQ*DW  event value, requester i at [i*DW +: DW]
req_delay  in  NREQ*DLY_W  delay in cycles, packed like req_data
req_mode  in  NREQ  0 = intra (capture at accept), 1 = inter (sample at issue)
live_data  in  NREQ*DW  live source value per requester, used by inter mode
out_valid  out  1  issued event valid
out_ready  in  1  downstream accept
out_data  out  DW  issued value
out_src  out  $clog2(NREQ)  originating requester index
pending  out  $clog2(SLOTS+1)  occupied slot count
late_cnt  out  16  stall statistics (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at a clk edge) clears all slots, the output register, the arbiter pointer (requester 0 highest priority next), and late_cnt. After reset: out_valid=0, out_data=0, out_src=0, pending=0. req_ready=0 while rst=1. Reset mid-countdown discards all pending events without issuing them.
- Admission:
  - When at least one slot is free, the round-robin arbiter grants the first requesting index after the last grant.
  - req_ready[g]=1 is combinational in the same cycle; a transfer occurs when req_valid&req_ready.
  - The pointer advances only on a transfer.
  - The event is written to the lowest-index free slot: cnt=req_delay, src=g, mode=req_mode[g], data=req_data[g].
- Full: with no free slot, all req_ready=0. A slot freed by issue in cycle T is allocatable in cycle T+1, not combinationally in T.
- Countdown: every cycle, each occupied slot with cnt>0 decrements. cnt==0 marks the slot expired; an expired slot holds at 0.
- Issue:
  - The output register loads when it is empty or out_ready=1.
  - It loads the lowest-index expired slot. out_data = slot data (intra) or live_data[src] in that cycle (inter).
  - That slot frees on the same edge.
- Latency: accept at edge T with delay D gives out_valid=1 from edge T+D+1 when uncontended. D=0 issues at T+1.
- Backpressure: out_valid/out_data/out_src hold stable while out_valid&!out_ready. Expired slots wait; non-expired slots keep counting.
- Simultaneous events: admission and issue in the same cycle are both allowed. pending updates as +1, -1, or unchanged accordingly.
- A requester may have multiple events in flight. The relative order between slots expiring on the same cycle is by slot index, not arrival.

Optional Feature:
- Macro: DSCHED_LATE_CNT_EN
- With the macro: late_cnt increments by 1 for every cycle in which at least one expired slot exists but cannot be loaded (output register full and out_ready=0). The counter saturates at 16'hFFFF and clears on reset.
- Without the macro: late_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package dsched_pkg:
  - slot_t struct {valid, cnt[DLY_W], src, mode, data[DW]}
  - mode enum {MODE_INTRA=0, MODE_INTER=1}
  - late_cnt width constant LATE_W=16
- Sub-module: dsched_rr_arb (NREQ-way round-robin arbiter, combinational grant, registered pointer update on transfer). The slot table and issue logic stay in the top level.

Test Plan:
1. Reset, then a single intra event from req 1 with data=1, delay=5, accepted at edge T. Expect out_valid at T+6, out_data=1, out_src=1, pending 1→0 on issue.
2. Inter event from req 0 with delay=5 and live_data[0] toggled 1→0 at T+3. Expect out_data=0 (the value at issue). The same test in intra mode gives 1.
3. All 4 requesters valid continuously with delay=0. Expect grants in order 0,1,2,3,0…, one per cycle, and out_src following the same order with 1-cycle latency.
4. Fill 8 slots with delay=15 and hold out_ready=0. Expect req_ready=0 and pending=8. Release out_ready; after the first issue, expect req_ready returns one cycle later.
5. Two events expiring on the same cycle with out_ready=0 for 3 cycles:
   - Outputs stay stable while stalled.
   - The lowest slot issues first.
   - With DSCHED_LATE_CNT_EN, late_cnt=3; without it, late_cnt=0.
6. Assert rst for 1 cycle with 3 events pending. Expect out_valid=0 and pending=0 the next cycle, and no stale event issued afterwards.
